// File: rtl/neuron_pkg.sv
// Shared FSM encoding and accumulator width constants for the neuron sequencer.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One extra headroom bit on the accumulator adder exposes signed overflow.
    localparam int SAT_GUARD = 1;

endpackage

// File: rtl/neuron_seq_mult_add.sv
// Chunk datapath: PARALLEL_IN signed products summed, realigned to the output
// format, saturated, then delayed through a LAT-deep register pipe.
module mult_add #(
    parameter int LANES = 4,
    parameter int DW    = 16,
    parameter int DI    = 2,
    parameter int WW    = 16,
    parameter int WI    = 2,
    parameter int OW    = 32,
    parameter int OI    = 16,
    parameter int LAT   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES-1:0][DW-1:0]  a,
    input  logic [LANES-1:0][WW-1:0]  b,
    output logic [OW-1:0]             dout
);

    localparam int MW  = DW + WW;
    localparam int PW0 = MW + $clog2(LANES) + 1;
    localparam int PW  = (PW0 > OW) ? PW0 : OW + 1;
    localparam int SH  = (DW - DI) + (WW - WI) - (OW - OI);

    logic signed [MW-1:0] prod [LANES];
    logic signed [PW-1:0] sum, shf;
    logic [OW-1:0]        sat;
    logic [LAT-1:0][OW-1:0] pipe;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign prod[g] = MW'($signed(a[g])) * MW'($signed(b[g]));
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) sum = sum + PW'(prod[i]);
        shf = sum >>> SH;
        // Upper bits not all equal to the sign means the value exceeds OW.
        if (shf[PW-1:OW-1] != {(PW-OW+1){shf[PW-1]}})
            sat = shf[PW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        else
            sat = shf[OW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= sat;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign dout = pipe[LAT-1];

endmodule

// File: rtl/neuron_seq.sv
// Sequential neuron: streams N_CHUNKS input chunks against a stored weight
// file, accumulates the product-sums with saturation and hands out one sum.
module neuron_seq
    import neuron_pkg::*;
#(
    parameter int PARALLEL_IN  = 4,
    parameter int N_CHUNKS     = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int DATA_INT     = 2,
    parameter int WEIGHT_WIDTH = 16,
    parameter int WEIGHT_INT   = 2,
    parameter int OUT_WIDTH    = 32,
    parameter int OUT_INT      = 16,
    parameter int MULT_LAT     = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [PARALLEL_IN*DATA_WIDTH-1:0]             din,
    input  logic                                          din_valid,
    output logic                                          din_ready,
    input  logic                                          w_we,
    input  logic [((N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1)-1:0] w_addr,
    input  logic [PARALLEL_IN*WEIGHT_WIDTH-1:0]           w_data,
    output logic [OUT_WIDTH-1:0]                          dout,
    output logic                                          dout_valid,
    input  logic                                          dout_ready,
    output logic                                          busy
);

    localparam int AW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int L  = MULT_LAT;
    localparam int OW = OUT_WIDTH;
    localparam int SW = OW + SAT_GUARD;

    state_t state, nxt;
    logic [AW-1:0] cnt, idx;
    logic [PARALLEL_IN*WEIGHT_WIDTH-1:0] wmem [N_CHUNKS];
    logic [PARALLEL_IN*WEIGHT_WIDTH-1:0] wsel;
    logic [L:1] vld_pipe, lst_pipe;
    logic xfer, last, fin, ma_rst;
    logic [OW-1:0] res, acc, acc_sat;
    logic signed [SW-1:0] acc_sum;

    assign xfer = din_valid && din_ready;
    assign idx  = (state == IDLE) ? '0 : cnt;
    assign last = (idx == AW'(N_CHUNKS - 1));
    assign wsel = wmem[idx];

    // Weight file is not reset; writes only land while idle, and the read
    // above still sees the old word during a same-cycle write.
    always_ff @(posedge clk) begin
        if (w_we && state == IDLE) wmem[w_addr] <= w_data;
    end

    assign ma_rst = ~rst;

    mult_add #(
        .LANES(PARALLEL_IN), .DW(DATA_WIDTH), .DI(DATA_INT),
        .WW(WEIGHT_WIDTH), .WI(WEIGHT_INT), .OW(OUT_WIDTH), .OI(OUT_INT), .LAT(MULT_LAT)
    ) u_mult_add (
        .clk  (clk),
        .rst  (ma_rst),
        .a    (din),
        .b    (wsel),
        .dout (res)
    );

    always_comb begin
        acc_sum = $signed({acc[OW-1], acc}) + $signed({res[OW-1], res});
        if (acc_sum[SW-1] != acc_sum[SW-2])
            acc_sat = acc_sum[SW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        else
            acc_sat = acc_sum[OW-1:0];
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE, RUN: if (xfer) nxt = last ? DRAIN : RUN;
            DRAIN:     if (fin) nxt = DONE;
            DONE:      if (dout_valid && dout_ready) nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            vld_pipe   <= '0;
            lst_pipe   <= '0;
            fin        <= 1'b0;
            acc        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            din_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state     <= nxt;
            din_ready <= (nxt == IDLE) || (nxt == RUN);
            busy      <= (nxt != IDLE);

            vld_pipe[1] <= xfer;
            lst_pipe[1] <= xfer && last;
            for (int k = 2; k <= L; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                lst_pipe[k] <= lst_pipe[k-1];
            end
            // Final result is in acc one cycle after it leaves the pipe.
            fin <= vld_pipe[L] && lst_pipe[L];

            if (xfer) cnt <= (state == IDLE) ? AW'(1) : cnt + AW'(1);

            if (state == IDLE && xfer) acc <= '0;
            else if (vld_pipe[L])      acc <= acc_sat;

            if (state == DRAIN && fin) begin
                dout       <= acc;
                dout_valid <= 1'b1;
            end else if (state == DONE && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule
